trs_video_capture: RTL
======================

Name: trs_video_capture

Overview:
Receive-side counterpart of the VGA text/LE18 generator. It digitises the native TRS-80 Model I monochrome video stream (serial pixel data plus HSYNC and VSYNC), recovers the 384x192 active raster, and packs 6 pixels per word. Each word is written into a frame buffer that uses the same addressing and bit order as the LE18 graphics RAM. It sits between the TRS-80 video header pins and a write port of a dual-port block RAM.

Parameters:
CLKS_PER_PIXEL, 8, clk cycles per source dot (clk runs at 8x the dot clock); legal range 2-15.
H_OFFSET, 12, whole pixels from the HSYNC rising edge to the first active pixel.
V_OFFSET, 30, HSYNC rising edges after the VSYNC rising edge before active line 0.
ACTIVE_H, 192, active lines per frame.
HS_TIMEOUT, 8191, clk cycles without an HSYNC rising edge before sync is declared lost.

Ports:
clk  in  1  system clock
srst  in  1  reset, asynchronous, active-high
vid_in  in  1  raw pixel data (asynchronous to clk), 1 = lit
hsync_in  in  1  raw horizontal sync, active-high
vsync_in  in  1  raw vertical sync, active-high
capture_en  in  1  level; 1 = capture frames continuously
err_clr  in  1  single-cycle pulse; clears the sticky error flags
wr_en  out  1  single-cycle frame-buffer write strobe
wr_addr  out  14  {line[7:0], col[5:0]}
wr_data  out  6  bit0 = leftmost pixel, bit5 = rightmost
frame_done  out  1  single-cycle pulse after the last word of line ACTIVE_H-1
locked  out  1  1 once a complete frame has been captured
err_short_line  out  1  sticky flag
err_short_frame  out  1  sticky flag
err_sync_lost  out  1  sticky flag
line_period  out  16  clk cycles between the last two HSYNC rising edges; saturates at 16'hFFFF

Behaviour:
- Reset (asynchronous): state IDLE. All outputs are 0; all counters and the shift register are 0.
- Input synchronisation: each of vid_in, hsync_in and vsync_in passes through a 2-FF synchroniser. Rising-edge detect is done on the synchronised sync signals. Pin-to-edge latency is 3 clk.
- FSM states:
  - IDLE: when capture_en = 1, go to WAIT_VS.
  - WAIT_VS: on a VSYNC rising edge, clear line to 0 and the V-skip count to 0, go to VSKIP.
  - VSKIP: count HSYNC rising edges. On the V_OFFSET-th edge, go to HSKIP. That edge also starts line 0.
  - LINE_WAIT: on an HSYNC rising edge, go to HSKIP.
  - HSKIP: clear the phase counter and the pixel counter on entry. Wait H_OFFSET*CLKS_PER_PIXEL clk, then go to ACTIVE.
  - ACTIVE:
    - The phase counter runs 0..CLKS_PER_PIXEL-1. The synchronised vid is sampled at phase CLKS_PER_PIXEL/2 (integer divide).
    - Sample k of each group (k = 0..5) goes into shift bit k.
    - After the 6th sample, register wr_en = 1 on the next clk. wr_data is the assembled word; wr_addr = {line, col}. col then increments.
    - After col 63 is written (384 pixels): line increments. If the new line equals ACTIVE_H, pulse frame_done in the same cycle as the state change, set locked = 1, and go to WAIT_VS (capture_en = 1) or IDLE (capture_en = 0). Otherwise go to LINE_WAIT.
- Short line: an HSYNC rising edge while in ACTIVE or HSKIP.
  - Set err_short_line.
  - The partial word is discarded and is not written.
  - line increments and HSKIP restarts for the new line. Words already written stay in the buffer.
- Short frame: a VSYNC rising edge in any state except IDLE or WAIT_VS.
  - Set err_short_frame, clear locked.
  - Clear line to 0 and the V-skip count to 0, go to VSKIP. No frame_done.
- Sync lost: a free-running counter is cleared on every HSYNC rising edge. When it exceeds HS_TIMEOUT in any state except IDLE:
  - Set err_sync_lost, clear locked, go to WAIT_VS.
  - The counter holds at HS_TIMEOUT+1 until the next HSYNC edge.
- line_period: on every HSYNC rising edge, latch the edge-to-edge count and restart it. Updates in every state, including IDLE.
- capture_en falling mid-frame: go to IDLE on the next clk.
  - A wr_en already registered for that clk still completes.
  - No further writes. No frame_done. locked is unchanged.
- err_clr: clears all three sticky flags. If an error sets in the same cycle, the set wins.
- Simultaneous HSYNC and VSYNC edges: VSYNC handling takes priority.
- Arithmetic: line is 8-bit, col is 6-bit, pixel-in-word is 3-bit, phase is 4-bit. The wrap cases (col 63, pixel 5, line ACTIVE_H-1) are compared explicitly; nothing relies on natural overflow.
- Throughput: at most one write every 6*CLKS_PER_PIXEL clk, so no backpressure port exists. The frame buffer accepts one write per clk unconditionally.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE, WAIT_VS, VSKIP, LINE_WAIT, HSKIP, ACTIVE)
  - constants PIX_PER_WORD = 6, WORDS_PER_LINE = 64, ADDR_W = 14
- One sub-module is natural: trs_sync_edge, a 2-FF synchroniser plus rising-edge detect, instantiated three times (the vid instance leaves its edge output unused).

Test Plan:
1. Bench settings: CLKS_PER_PIXEL = 4, H_OFFSET = 2, V_OFFSET = 1, ACTIVE_H = 4. Stimulus: a frame where pixel n of line L is lit iff n == L. Required:
   - 256 writes.
   - The word at addr {L, 0} has wr_data = 6'b1 << L for L = 0..3; every other word is 0.
   - frame_done pulses once; locked = 1.
2. Alternating 1/0 pixels on every line -> every wr_data = 6'b010101; wr_addr runs 0..255 in order.
3. HSYNC edge after 200 pixels of line 1 -> err_short_line = 1; no write for col >= 33 (200/6 = 33 complete words) on line 1; line 2 is captured normally.
4. VSYNC edge during line 2 -> err_short_frame = 1, locked = 0, no frame_done; the next full frame completes with frame_done.
5. Stop HSYNC for 9000 clk (HS_TIMEOUT = 8191) -> err_sync_lost = 1 and locked = 0. Then pulse err_clr -> all three flags = 0.
6. Assert srst mid-ACTIVE -> all outputs 0 immediately; after release with capture_en = 1, capture resumes on the next VSYNC. Separately, drive HSYNC with a 512-clk period -> line_period = 512.

Source files
------------

// File: rtl/trs_video_capture_pkg.sv
// rtl/trs_video_capture_pkg.sv - shared types and constants for the TRS-80 video capture block
package trs_video_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        VSKIP,
        LINE_WAIT,
        HSKIP,
        ACTIVE
    } cap_state_t;

    localparam int PIX_PER_WORD   = 6;
    localparam int WORDS_PER_LINE = 64;
    localparam int ADDR_W         = 14;

endpackage

// File: rtl/trs_sync_edge.sv
// rtl/trs_sync_edge.sv - two-flop synchroniser with rising-edge detect
module trs_sync_edge (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic sync,
    output logic rise
);

    logic meta;
    logic prev;

    // Two flops of metastability settling, plus one more to remember the previous level
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/trs_video_capture.sv
// rtl/trs_video_capture.sv - recovers the 384x192 TRS-80 raster and writes 6-pixel words to a frame buffer
module trs_video_capture
    import trs_video_capture_pkg::*;
#(
    parameter int CLKS_PER_PIXEL = 8,
    parameter int H_OFFSET       = 12,
    parameter int V_OFFSET       = 30,
    parameter int ACTIVE_H       = 192,
    parameter int HS_TIMEOUT     = 8191
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    vid_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    capture_en,
    input  logic                    err_clr,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [PIX_PER_WORD-1:0] wr_data,
    output logic                    frame_done,
    output logic                    locked,
    output logic                    err_short_line,
    output logic                    err_short_frame,
    output logic                    err_sync_lost,
    output logic [15:0]             line_period
);

    localparam logic [3:0]  PHASE_LAST  = 4'(CLKS_PER_PIXEL - 1);
    localparam logic [3:0]  PHASE_SAMP  = 4'(CLKS_PER_PIXEL / 2);
    localparam logic [15:0] HSKIP_LAST  = 16'(H_OFFSET * CLKS_PER_PIXEL - 1);
    localparam logic [7:0]  VSKIP_LAST  = 8'(V_OFFSET - 1);
    localparam logic [7:0]  LINE_LAST   = 8'(ACTIVE_H - 1);
    localparam logic [5:0]  COL_LAST    = 6'(WORDS_PER_LINE - 1);
    localparam logic [2:0]  PIX_LAST    = 3'(PIX_PER_WORD - 1);
    localparam logic [15:0] TIMEOUT     = 16'(HS_TIMEOUT);

    logic vid_s, vid_rise_unused;
    logic hs_s, hs_rise;
    logic vs_s, vs_rise;

    trs_sync_edge u_vid (.clk(clk), .srst(srst), .din(vid_in),   .sync(vid_s), .rise(vid_rise_unused));
    trs_sync_edge u_hs  (.clk(clk), .srst(srst), .din(hsync_in), .sync(hs_s),  .rise(hs_rise));
    trs_sync_edge u_vs  (.clk(clk), .srst(srst), .din(vsync_in), .sync(vs_s),  .rise(vs_rise));

    cap_state_t state, state_n;

    logic [7:0]              line;
    logic [5:0]              col;
    logic [2:0]              pix;
    logic [3:0]              phase;
    logic [PIX_PER_WORD-1:0] shift;
    logic [7:0]              vskip_cnt;
    logic [15:0]             hskip_cnt;
    logic [15:0]             hs_timer;
    logic [15:0]             per_cnt;

    logic restart_v, short_frame, sync_lost, short_line, enter_hskip;
    logic vskip_inc, sample, word_done, line_done, frame_end;

    // State register
    always_ff @(posedge clk or posedge srst) begin
        if (srst) state <= IDLE;
        else      state <= state_n;
    end

    // Next state and per-cycle action strobes; capture_en drop beats vsync, vsync beats sync loss, which beats hsync
    always_comb begin
        state_n     = state;
        restart_v   = 1'b0;
        short_frame = 1'b0;
        sync_lost   = 1'b0;
        short_line  = 1'b0;
        enter_hskip = 1'b0;
        vskip_inc   = 1'b0;
        sample      = 1'b0;
        word_done   = 1'b0;
        line_done   = 1'b0;
        frame_end   = 1'b0;
        if (state == IDLE) begin
            if (capture_en) state_n = WAIT_VS;
        end else if (!capture_en) begin
            state_n = IDLE;
        end else if (vs_rise) begin
            restart_v   = 1'b1;
            short_frame = (state != WAIT_VS);
            state_n     = VSKIP;
        end else if (hs_timer > TIMEOUT) begin
            sync_lost = 1'b1;
            state_n   = WAIT_VS;
        end else begin
            case (state)
                VSKIP: begin
                    if (hs_rise) begin
                        if (vskip_cnt == VSKIP_LAST) begin
                            enter_hskip = 1'b1;
                            state_n     = HSKIP;
                        end else begin
                            vskip_inc = 1'b1;
                        end
                    end
                end
                LINE_WAIT: begin
                    if (hs_rise) begin
                        enter_hskip = 1'b1;
                        state_n     = HSKIP;
                    end
                end
                HSKIP, ACTIVE: begin
                    if (hs_rise) begin
                        // Line ended early: drop the partial word and start the next line
                        short_line = 1'b1;
                        line_done  = 1'b1;
                        if (line == LINE_LAST) begin
                            state_n = WAIT_VS;
                        end else begin
                            enter_hskip = 1'b1;
                            state_n     = HSKIP;
                        end
                    end else if (state == HSKIP) begin
                        if (hskip_cnt == HSKIP_LAST) state_n = ACTIVE;
                    end else if (phase == PHASE_SAMP) begin
                        sample = 1'b1;
                        if (pix == PIX_LAST) begin
                            word_done = 1'b1;
                            if (col == COL_LAST) begin
                                line_done = 1'b1;
                                if (line == LINE_LAST) begin
                                    frame_end = 1'b1;
                                    state_n   = WAIT_VS;
                                end else begin
                                    state_n = LINE_WAIT;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Raster position counters, pixel shifter and frame-buffer write port
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            line       <= '0;
            col        <= '0;
            pix        <= '0;
            phase      <= '0;
            shift      <= '0;
            vskip_cnt  <= '0;
            hskip_cnt  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= word_done;
            frame_done <= frame_end;
            if (word_done) begin
                wr_addr <= {line, col};
                wr_data <= {vid_s, shift[PIX_PER_WORD-2:0]};
            end
            if (restart_v) begin
                line      <= '0;
                vskip_cnt <= '0;
            end else begin
                if (vskip_inc) vskip_cnt <= vskip_cnt + 1'b1;
                if (line_done) line <= (line == LINE_LAST) ? '0 : line + 1'b1;
            end
            if (enter_hskip) begin
                hskip_cnt <= '0;
                phase     <= '0;
                pix       <= '0;
                col       <= '0;
                shift     <= '0;
            end else begin
                if (state == HSKIP)  hskip_cnt <= hskip_cnt + 1'b1;
                if (state == ACTIVE) phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
                if (sample) begin
                    shift[pix] <= vid_s;
                    pix        <= (pix == PIX_LAST) ? '0 : pix + 1'b1;
                end
                if (word_done) col <= (col == COL_LAST) ? '0 : col + 1'b1;
            end
        end
    end

    // Sticky error flags (a new error wins over err_clr) and the lock indicator
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            locked          <= 1'b0;
            err_short_line  <= 1'b0;
            err_short_frame <= 1'b0;
            err_sync_lost   <= 1'b0;
        end else begin
            if (short_frame || sync_lost) locked <= 1'b0;
            else if (frame_end)           locked <= 1'b1;
            if (short_line)    err_short_line  <= 1'b1;
            else if (err_clr)  err_short_line  <= 1'b0;
            if (short_frame)   err_short_frame <= 1'b1;
            else if (err_clr)  err_short_frame <= 1'b0;
            if (sync_lost)     err_sync_lost   <= 1'b1;
            else if (err_clr)  err_sync_lost   <= 1'b0;
        end
    end

    // HSYNC watchdog and line-period measurement, active in every state
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            hs_timer    <= '0;
            per_cnt     <= '0;
            line_period <= '0;
        end else if (hs_rise) begin
            hs_timer    <= '0;
            per_cnt     <= '0;
            line_period <= (per_cnt == 16'hFFFF) ? per_cnt : per_cnt + 1'b1;
        end else begin
            if (hs_timer <= TIMEOUT)   hs_timer <= hs_timer + 1'b1;
            if (per_cnt != 16'hFFFF)   per_cnt  <= per_cnt + 1'b1;
        end
    end

endmodule
